// File: rtl/tile_map_renderer.sv
// Tile-map pixel renderer: Avalon-MM map/bg registers, hardware map clear,
// sprite ROM lookup with colour-key transparency and latency-matched sync.
module tile_map_renderer #(
  parameter int TILE_LOG2   = 4,
  parameter int COLS        = 40,
  parameter int ROWS        = 30,
  parameter int NUM_SPRITES = 16,
  parameter int ROM_LAT     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           chipselect,
  input  logic                           write,
  input  logic                           read,
  input  logic [2:0]                     address,
  input  logic [7:0]                     writedata,
  output logic [7:0]                     readdata,
  input  logic [10:0]                    hcount,
  input  logic [9:0]                     vcount,
  input  logic                           blank_n_in,
  input  logic                           hs_in,
  input  logic                           vs_in,
  output logic [$clog2(NUM_SPRITES)-1:0] sprite_id,
  output logic [2*TILE_LOG2-1:0]         sprite_addr,
  input  logic [15:0]                    sprite_data,
  output logic [7:0]                     VGA_R,
  output logic [7:0]                     VGA_G,
  output logic [7:0]                     VGA_B,
  output logic                           VGA_HS,
  output logic                           VGA_VS,
  output logic                           VGA_BLANK_n
);

  localparam int N   = COLS * ROWS;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int IDW = $clog2(NUM_SPRITES);
  localparam int TW  = TILE_LOG2;
  localparam int L   = 3 + ROM_LAT;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] clr_idx, clr_idx_d;
  logic          busy;

  logic [7:0] x_q, y_q;
  logic [7:0] bg_r, bg_g, bg_b;
  logic       wr_en, ctrl_go, commit;
  logic [IW-1:0] commit_idx;

  logic [7:0] map_mem [N];

  assign busy    = (state_q == CLEAR);
  assign wr_en   = chipselect && write;
  assign ctrl_go = wr_en && (address == 3'd6) && writedata[0];
  assign commit  = wr_en && (address == 3'd2) && !busy
                && (int'(x_q) < COLS) && (int'(y_q) < ROWS);
  assign commit_idx = IW'(int'(y_q) * COLS + int'(x_q));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx;
    unique case (state_q)
      IDLE: begin
        if (ctrl_go) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx + 1'b1;
        if (clr_idx == IW'(N - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      clr_idx <= clr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      bg_r <= '0;
      bg_g <= '0;
      bg_b <= '0;
    end else if (wr_en) begin
      unique case (address)
        3'd0: x_q  <= writedata;
        3'd1: y_q  <= writedata;
        3'd3: bg_r <= writedata;
        3'd4: bg_g <= writedata;
        3'd5: bg_b <= writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else if (chipselect && read)
      readdata <= (address == 3'd7) ? {7'd0, busy} : 8'd0;
  end

  // Clear owns the write port; commits are already blocked while busy.
  always_ff @(posedge clk) begin
    if (busy)
      map_mem[clr_idx] <= 8'd0;
    else if (commit)
      map_mem[commit_idx] <= writedata;
  end

  logic [9:0]    px_col, px_row;
  logic          s1_in;
  logic [IW-1:0] s1_idx;
  logic [TW-1:0] s1_tx, s1_ty, s2_tx, s2_ty;
  logic [7:0]    s2_type;
  logic          s3_bg;
  logic [ROM_LAT-1:0] bgf;
  logic [L-1:0]  hs_sr, vs_sr, bl_sr;
  logic          use_bg;
  logic [7:0]    px_r, px_g, px_b;
  logic          unused;

  assign unused = &{1'b0, hcount[0]};
  assign px_col = hcount[10:1] >> TILE_LOG2;
  assign px_row = vcount >> TILE_LOG2;
  assign s3_bg  = (s2_type == 8'd0) || (int'(s2_type) > NUM_SPRITES);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_in       <= 1'b0;
      s1_idx      <= '0;
      s1_tx       <= '0;
      s1_ty       <= '0;
      s2_type     <= '0;
      s2_tx       <= '0;
      s2_ty       <= '0;
      sprite_id   <= '0;
      sprite_addr <= '0;
      bgf         <= '1;
    end else begin
      s1_in   <= (int'(px_col) < COLS) && (int'(px_row) < ROWS);
      s1_idx  <= IW'(int'(px_row) * COLS + int'(px_col));
      s1_tx   <= hcount[TW:1];
      s1_ty   <= vcount[TW-1:0];
      s2_type <= s1_in ? map_mem[s1_idx] : 8'd0;
      s2_tx   <= s1_tx;
      s2_ty   <= s1_ty;
      sprite_id   <= IDW'(s2_type - 8'd1);
      sprite_addr <= {s2_ty, s2_tx};
      bgf[0]  <= s3_bg;
      for (int i = 1; i < ROM_LAT; i++)
        bgf[i] <= bgf[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sr <= '1;
      vs_sr <= '1;
      bl_sr <= '0;
    end else begin
      hs_sr[0] <= hs_in;
      vs_sr[0] <= vs_in;
      bl_sr[0] <= blank_n_in;
      for (int i = 1; i < L; i++) begin
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
        bl_sr[i] <= bl_sr[i-1];
      end
    end
  end

  assign VGA_HS      = hs_sr[L-1];
  assign VGA_VS      = vs_sr[L-1];
  assign VGA_BLANK_n = bl_sr[L-1];

  // 0xF81F is the magenta colour key.
  always_comb begin
    use_bg = bgf[ROM_LAT-1] || (sprite_data == 16'hF81F);
    px_r   = {sprite_data[15:11], sprite_data[15:13]};
    px_g   = {sprite_data[10:5], sprite_data[10:9]};
    px_b   = {sprite_data[4:0], sprite_data[4:2]};
    if (use_bg) begin
      px_r = bg_r;
      px_g = bg_g;
      px_b = bg_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      VGA_R <= bl_sr[L-2] ? px_r : 8'd0;
      VGA_G <= bl_sr[L-2] ? px_g : 8'd0;
      VGA_B <= bl_sr[L-2] ? px_b : 8'd0;
    end
  end

endmodule

// File: tb/tb_tile_map_renderer.sv
// Randomized bench for tile_map_renderer against a frame-level reference
// model (tile map array, sprite table, background colour, clear window).
module tb_tile_map_renderer;

  localparam int TILE_LOG2 = 4;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int NS = 16;
  localparam int ROM_LAT = 3;
  localparam int L = 3 + ROM_LAT;
  localparam int N = COLS * ROWS;
  localparam int TILE = 16;

  logic        clk, reset;
  logic        cs, wr, rd;
  logic [2:0]  address;
  logic [7:0]  writedata, readdata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        blank_n_in, hs_in, vs_in;
  logic [3:0]  sprite_id;
  logic [7:0]  sprite_addr;
  logic [15:0] sprite_data;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_n;

  tile_map_renderer #(
    .TILE_LOG2(TILE_LOG2), .COLS(COLS), .ROWS(ROWS),
    .NUM_SPRITES(NS), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .chipselect(cs), .write(wr), .read(rd),
    .address(address), .writedata(writedata), .readdata(readdata),
    .hcount(hcount), .vcount(vcount),
    .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
    .sprite_id(sprite_id), .sprite_addr(sprite_addr),
    .sprite_data(sprite_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [15:0] rom [NS][256];
  logic [11:0] rp1, rp2;

  always @(posedge clk) begin
    rp1 <= {sprite_id, sprite_addr};
    rp2 <= rp1;
  end
  assign sprite_data = rom[rp2[11:8]][rp2[7:0]];

  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks, fails, cyc, clr_start;
  int   ref_map [ROWS][COLS];
  int   mx, my;
  logic [7:0] m_bg_r, m_bg_g, m_bg_b;
  bit   rd_pend;
  logic [7:0] rd_exp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic bit busy_at(int r);
    return (r >= clr_start) && (r < clr_start + N);
  endfunction

  function automatic int rep(int v, int bits);
    return (v << (8 - bits)) | (v >> (2 * bits - 8));
  endfunction

  function automatic logic [23:0] exp_px(int h, int v, bit bl);
    int col, row, tx, ty, t, d;
    logic [23:0] bgc;
    bgc = {m_bg_r, m_bg_g, m_bg_b};
    if (!bl) return 24'd0;
    col = (h / 2) / TILE;
    row = v / TILE;
    tx  = (h / 2) % TILE;
    ty  = v % TILE;
    t   = (col < COLS && row < ROWS) ? ref_map[row][col] : 0;
    if (t == 0 || t > NS) return bgc;
    d = int'(rom[t-1][ty * TILE + tx]);
    if (d == 'hF81F) return bgc;
    return 24'((rep(d / 2048, 5) << 16) |
               (rep((d / 32) % 64, 6) << 8) |
               rep(d % 32, 5));
  endfunction

  task automatic drive_pix(input int h, input int v, input bit bl);
    exp_t e;
    hcount     = 11'(h);
    vcount     = 10'(v);
    blank_n_in = bl;
    hs_in      = 1'($urandom);
    vs_in      = 1'($urandom);
    e.hs  = hs_in;
    e.vs  = vs_in;
    e.bl  = bl;
    e.rgb = exp_px(h, v, bl);
    q.push_back(e);
  endtask

  task automatic cyc_pix(input int h, input int v, input bit bl);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() == L) begin
      e = q.pop_front();
      chk("hs", 32'(VGA_HS), 32'(e.hs));
      chk("vs", 32'(VGA_VS), 32'(e.vs));
      chk("blank", 32'(VGA_BLANK_n), 32'(e.bl));
      chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
    end
    if (rd_pend) begin
      chk("readdata", 32'(readdata), 32'(rd_exp));
      rd_pend = 1'b0;
    end
    cs = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    drive_pix(h, v, bl);
  endtask

  task automatic idle_cyc();
    cyc_pix(int'($urandom_range(0, 1599)), int'($urandom_range(0, 524)), 1'b0);
  endtask

  task automatic model_zero();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        ref_map[r][c] = 0;
  endtask

  task automatic bus_wr(input int a, input int d);
    idle_cyc();
    cs = 1'b1;
    wr = 1'b1;
    address = 3'(a);
    writedata = 8'(d);
    case (a)
      0: mx = d;
      1: my = d;
      2: if (!busy_at(cyc) && mx < COLS && my < ROWS) ref_map[my][mx] = d;
      3: m_bg_r = 8'(d);
      4: m_bg_g = 8'(d);
      5: m_bg_b = 8'(d);
      6: if ((d % 2) == 1 && !busy_at(cyc)) begin
        clr_start = cyc + 1;
        model_zero();
      end
      default: ;
    endcase
  endtask

  task automatic bus_rd(input int a);
    idle_cyc();
    cs = 1'b1;
    rd = 1'b1;
    address = 3'(a);
    rd_pend = 1'b1;
    rd_exp = (a == 7) ? {7'd0, busy_at(cyc)} : 8'd0;
  endtask

  task automatic commit(input int x, input int y, input int t);
    bus_wr(0, x);
    bus_wr(1, y);
    bus_wr(2, t);
  endtask

  task automatic pix_phase(input int n, input int h0, input int h1,
                           input int v0, input int v1);
    for (int i = 0; i < n; i++)
      cyc_pix(int'($urandom_range(h1, h0)), int'($urandom_range(v1, v0)),
              ($urandom % 10) != 0);
    repeat (L + 1) idle_cyc();
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    cs = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    blank_n_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    chk("rst_hs", 32'(VGA_HS), 32'd1);
    chk("rst_vs", 32'(VGA_VS), 32'd1);
    chk("rst_blank", 32'(VGA_BLANK_n), 32'd0);
    chk("rst_readdata", 32'(readdata), 32'd0);
    chk("rst_sprite_id", 32'(sprite_id), 32'd0);
    chk("rst_sprite_addr", 32'(sprite_addr), 32'd0);
    reset = 1'b0;
    clr_start = cyc;
    model_zero();
    mx = 0;
    my = 0;
    m_bg_r = 8'd0;
    m_bg_g = 8'd0;
    m_bg_b = 8'd0;
    rd_pend = 1'b0;
    q.delete();
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.bl = 1'b0;
    e.rgb = 24'd0;
    repeat (L - 1) q.push_back(e);
    drive_pix(0, 0, 1'b0);
  endtask

  initial begin
    int c0;
    checks = 0;
    fails = 0;
    cyc = 0;
    address = 3'd0;
    writedata = 8'd0;
    hcount = 11'd0;
    vcount = 10'd0;
    hs_in = 1'b1;
    vs_in = 1'b1;
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < 256; a++)
        rom[s][a] = 16'($urandom);
    for (int a = 0; a < 256; a++) begin
      rom[2][a] = 16'h07E0;
      if ($urandom_range(0, 3) == 0) rom[0][a] = 16'hF81F;
      if ($urandom_range(0, 7) == 0) rom[5][a] = 16'hF81F;
    end

    do_reset();
    bus_rd(0);
    while (cyc < clr_start + N + 4) bus_rd(7);
    pix_phase(200, 0, 1599, 0, 524);

    commit(2, 1, 3);
    pix_phase(60, 64, 95, 16, 31);
    repeat (4) cyc_pix(70, 18, 1'b1);
    chk("sprite_addr_35_18", 32'(sprite_addr), 32'h23);
    chk("sprite_id_35_18", 32'(sprite_id), 32'd2);
    repeat (L + 1) idle_cyc();

    bus_wr(3, 'h10);
    bus_wr(4, 'h20);
    bus_wr(5, 'h30);
    commit(0, 0, 1);
    commit(1, 0, 17);
    pix_phase(120, 0, 63, 0, 15);

    commit(40, 0, 1);
    commit(0, 30, 1);
    pix_phase(150, 0, 1599, 0, 524);

    for (int i = 0; i < 60; i++)
      commit(int'($urandom_range(0, COLS - 1)),
             int'($urandom_range(0, ROWS - 1)),
             int'($urandom_range(0, 20)));
    bus_wr(3, int'($urandom_range(0, 255)));
    pix_phase(400, 0, 1599, 0, 524);

    bus_wr(0, 3);
    bus_wr(1, 3);
    bus_wr(6, 1);
    c0 = cyc;
    while (cyc < c0 + 4) bus_rd(7);
    bus_wr(2, 5);
    while (cyc < c0 + 100) bus_rd(7);
    bus_wr(6, 1);
    while (cyc < c0 + N + 4) bus_rd(7);
    pix_phase(200, 0, 1599, 0, 524);
    commit(3, 3, 6);
    pix_phase(80, 96, 127, 48, 63);

    bus_wr(6, 1);
    repeat (50) bus_rd(7);
    do_reset();
    while (cyc < clr_start + N + 3) bus_rd(7);
    pix_phase(100, 0, 1599, 0, 524);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/tile_map_renderer.md
# tile_map_renderer

Parametrised tile-map pixel renderer for the VGA game display. Holds a COLS×ROWS map of tile types written over the Avalon-MM slave, looks up each screen pixel's tile, fetches the matching RGB565 texel from external sprite ROMs, and drives pipeline-aligned 24-bit VGA colour and sync. It sits between `vga_counters` (timing source) and the VGA DAC pins. Unlike the single-cycle lookup it replaces, it uses committed map writes, a hardware map-clear, transparency, a background colour and latency-matched sync.

## Interface
Parameters:
- TILE_LOG2, 4: tile edge = 2^TILE_LOG2 display pixels.
- COLS, 40: map columns; 1..2^(10-TILE_LOG2).
- ROWS, 30: map rows; 1..2^(9-TILE_LOG2).
- NUM_SPRITES, 16: sprite ROM count; map types 1..NUM_SPRITES are valid.
- ROM_LAT, 1: sprite ROM read latency in clocks, ≥1.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- chipselect, write, read  in  1 each  Avalon-MM slave strobes
- address  in  3  register select
- writedata  in  8  write data
- readdata  out  8  read data
- hcount  in  11  from vga_counters; hcount[10:1] = pixel column
- vcount  in  10  pixel row
- blank_n_in, hs_in, vs_in  in  1 each  raw timing from vga_counters
- sprite_id  out  $clog2(NUM_SPRITES)  ROM select
- sprite_addr  out  2*TILE_LOG2  texel address {row_in_tile, col_in_tile}
- sprite_data  in  16  RGB565 texel from selected ROM
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_HS, VGA_VS, VGA_BLANK_n  out  1 each  delayed sync/blank

## Operation
- Registers (write): 0 X, 1 Y, 2 TYPE (writing commits map[Y][X] ← writedata the same cycle, using the current X/Y), 3 BG_R, 4 BG_G, 5 BG_B, 6 CTRL (bit0=1 starts clear). Read: 7 STATUS, bit0=busy; other addresses read 0. readdata registered, one cycle after read&chipselect.
- Commit with X≥COLS or Y≥ROWS: dropped. Commit while busy: dropped.
- Map RAM: 8-bit cells, one write port (commit/clear), one registered read port (render).
- Clear FSM: IDLE→CLEAR on CTRL bit0 or reset; CLEAR writes 0 to cell index 0..COLS*ROWS−1, one per clock, then →IDLE. busy=1 in CLEAR. CTRL write during CLEAR ignored (no restart).
- Render: tile col = hcount[10:1]>>TILE_LOG2, row = vcount>>TILE_LOG2; texel = low TILE_LOG2 bits of each. Outside map area, type treated as 0.
- Type 0 or >NUM_SPRITES → background colour. Type k → sprite_id=k−1; texel 0xF81F (magenta key) → background.
- RGB565→888 by bit replication: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
- Blanked pixel (delayed blank_n=0) → RGB 0.

## Timing
- Pipeline, L = 3+ROM_LAT clocks input→output. Edge1: register coords/blank/sync, compute cell index. Edge2: map read → type. Edge3: sprite_id/sprite_addr and decision flags registered. Edge 3+ROM_LAT: sprite_data sampled, VGA_R/G/B registered.
- VGA_HS/VS/BLANK_n = hs_in/vs_in/blank_n_in delayed exactly L clocks (shift register).
- Map write visible to render from the pixel whose edge2 follows the write edge.
- Reset values: VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_n=0, readdata=0, sprite_id=0, sprite_addr=0, X/Y/TYPE/BG=0, delay line filled with inactive values (hs=1, vs=1, blank_n=0); FSM in CLEAR index 0, busy=1 for COLS*ROWS clocks.
- Reset mid-clear restarts clear at index 0.
- Background registers take effect on the next pixel at edge 3+ROM_LAT.

## Test plan
- Reset, defaults (COLS=40, ROWS=30): STATUS read =1 for 1200 clocks then 0; every visible pixel RGB 0; VGA_HS/VS match inputs delayed 4 clocks.
- Write X=2,Y=1,TYPE=3; ROM model returns 0x07E0 for id 2: pixels col 32..47, rows 16..31 → (0x00,0xFF,0x00); sprite_addr at col 35,row 18 = 0x23.
- BG=(0x10,0x20,0x30), ROM texel 0xF81F at cell (0,0): those pixels → (0x10,0x20,0x30); type 17 cell → background.
- Commit X=40,Y=0,TYPE=1: map unchanged, render unaffected.
- CTRL=1 after filling map: TYPE commit at clear cycle 5 dropped; after 1200 clocks all pixels background, busy 0.
- ROM_LAT=3: outputs and sync aligned at L=6; blanked pixels RGB 0 regardless of map.
